// File: rtl/finn_ctrl_sequencer.sv
// AXI4-Lite control initiator for a FINN HLS accelerator: writes buffer pointer
// and rep count, pulses ap_start, then polls ap_ctrl until ap_done or timeout.
module finn_ctrl_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  OFS_CTRL    = 8'h00,
  parameter logic [7:0]  OFS_ADDR_LO = 8'h10,
  parameter logic [7:0]  OFS_ADDR_HI = 8'h14,
  parameter logic [7:0]  OFS_REPS    = 8'h1C,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned MAX_POLLS   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_reps,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [1:0]  done_status,
  output logic        busy,
  output logic [31:0] m_aw_addr,
  output logic        m_aw_valid,
  input  logic        m_aw_ready,
  output logic [31:0] m_w_data,
  output logic [3:0]  m_w_strb,
  output logic        m_w_valid,
  input  logic        m_w_ready,
  input  logic [1:0]  m_b_resp,
  input  logic        m_b_valid,
  output logic        m_b_ready,
  output logic [31:0] m_ar_addr,
  output logic        m_ar_valid,
  input  logic        m_ar_ready,
  input  logic [31:0] m_r_data,
  input  logic [1:0]  m_r_resp,
  input  logic        m_r_valid,
  output logic        m_r_ready
);

  typedef enum logic [2:0] {
    IDLE, WR_ALO, WR_AHI, WR_REPS, WR_START, RD_POLL, POLL_WAIT, DONE
  } state_t;

  localparam logic [31:0] MAX_POLLS_W = 32'(MAX_POLLS);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
  localparam bit          TMO_EN      = (MAX_POLLS != 0);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_ERR = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  state_t      state, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] reps_q, reps_d;
  logic [31:0] poll_q, poll_d;
  logic [15:0] gap_q, gap_d;
  logic [1:0]  status_q, status_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ar_done_q, ar_done_d;

  logic        in_wr;
  logic [7:0]  wr_ofs;
  logic [31:0] wr_data;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  function automatic state_t next_wr(input state_t s);
    case (s)
      WR_ALO:  return WR_AHI;
      WR_AHI:  return WR_REPS;
      WR_REPS: return WR_START;
      default: return RD_POLL;
    endcase
  endfunction

  // Per-state register target; address/data are zero outside the write states.
  always_comb begin
    in_wr   = 1'b1;
    wr_ofs  = 8'h00;
    wr_data = 32'h0;
    case (state)
      WR_ALO:   begin wr_ofs = OFS_ADDR_LO; wr_data = addr_q; end
      WR_AHI:   begin wr_ofs = OFS_ADDR_HI; wr_data = 32'h0;  end
      WR_REPS:  begin wr_ofs = OFS_REPS;    wr_data = reps_q; end
      WR_START: begin wr_ofs = OFS_CTRL;    wr_data = 32'h1;  end
      default:  in_wr = 1'b0;
    endcase
  end

  // AW and W each hold until their own handshake; B waits for both.
  assign m_aw_valid = in_wr & ~aw_done_q;
  assign m_w_valid  = in_wr & ~w_done_q;
  assign m_b_ready  = in_wr & aw_done_q & w_done_q;
  assign m_aw_addr  = in_wr ? (BASE_ADDR + {24'h0, wr_ofs}) : 32'h0;
  assign m_w_data   = wr_data;
  assign m_w_strb   = 4'hF;

  assign m_ar_valid = (state == RD_POLL) & ~ar_done_q;
  assign m_r_ready  = (state == RD_POLL) & ar_done_q;
  assign m_ar_addr  = (state == RD_POLL) ? (BASE_ADDR + {24'h0, OFS_CTRL}) : 32'h0;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done_valid  = (state == DONE);
  assign done_status = status_q;

  assign aw_hs = m_aw_valid & m_aw_ready;
  assign w_hs  = m_w_valid  & m_w_ready;
  assign b_hs  = m_b_valid  & m_b_ready;
  assign ar_hs = m_ar_valid & m_ar_ready;
  assign r_hs  = m_r_valid  & m_r_ready;

  // Only ap_done is inspected in the polled word.
  logic unused_rdata;
  assign unused_rdata = ^{m_r_data[31:2], m_r_data[0]};

  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    reps_d    = reps_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    status_d  = status_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q  | w_hs;
    ar_done_d = ar_done_q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          reps_d   = cmd_reps;
          status_d = ST_OK;
          state_d  = WR_ALO;
        end
      end
      WR_ALO, WR_AHI, WR_REPS, WR_START: begin
        if (b_hs) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          poll_d    = 32'h0;
          if (m_b_resp != 2'b00) begin
            status_d = ST_ERR;
            state_d  = DONE;
          end else begin
            state_d = next_wr(state);
          end
        end
      end
      RD_POLL: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          ar_done_d = 1'b0;
          poll_d    = poll_q + 32'd1;
          if (m_r_resp != 2'b00) begin
            status_d = ST_ERR;
            state_d  = DONE;
          end else if (m_r_data[1]) begin
            status_d = ST_OK;
            state_d  = DONE;
          end else if (TMO_EN && (poll_q + 32'd1 == MAX_POLLS_W)) begin
            status_d = ST_TMO;
            state_d  = DONE;
          end else begin
            gap_d   = 16'h0;
            state_d = POLL_WAIT;
          end
        end
      end
      POLL_WAIT: begin
        if (gap_q == GAP_LAST) state_d = RD_POLL;
        else                   gap_d   = gap_q + 16'd1;
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= 32'h0;
      reps_q    <= 32'h0;
      poll_q    <= 32'h0;
      gap_q     <= 16'h0;
      status_q  <= ST_OK;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      reps_q    <= reps_d;
      poll_q    <= poll_d;
      gap_q     <= gap_d;
      status_q  <= status_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

endmodule
